// File: rtl/pipe_catch.sv
// pipe_catch: credit-gated catch FIFO for a fixed-latency, non-stallable pipe; LAT-cycle pipe, show-ahead output.
// Backpressure: down_ready stalls the FIFO and withholds credits, so up_ready drops before a return can overflow.
// Optional PIPE_CATCH_CHECK_EN adds a LAT-deep issue shadow that flags late, early or spurious returns on err.
module pipe_catch #(
   parameter int LAT   = 4,
   parameter int DSIZE = 32,
   parameter int DEPTH = 8,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic             pipe_out_valid,
   input  logic [DSIZE-1:0] pipe_out_data,
   output logic             down_valid,
   output logic [DSIZE-1:0] down_data,
   input  logic             down_ready,
   output logic [CW-1:0]    credit,
   output logic             ovf,
   output logic             err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   logic [CW-1:0]    inflight, inflight_nxt;
   logic [CW-1:0]    fifo_cnt, fifo_cnt_nxt;
   logic [AW-1:0]    wptr, rptr;
   logic [DSIZE-1:0] mem [DEPTH];
   logic [CW:0]      occ;
   logic             issue, pop, push, full, drop;
   logic             ovf_q;

   assign occ        = {1'b0, fifo_cnt} + {1'b0, inflight};
   assign up_ready   = occ < {1'b0, DEPTH_C};
   assign credit     = DEPTH_C - fifo_cnt - inflight;
   assign down_valid = fifo_cnt != '0;
   assign down_data  = mem[rptr];
   assign ovf        = ovf_q;

   assign issue = up_valid & up_ready;
   assign pop   = down_valid & down_ready;
   assign full  = fifo_cnt == DEPTH_C;
   // A same-cycle pop frees the head slot, so a return is always accepted then.
   assign push  = pipe_out_valid & (~full | pop);
   assign drop  = pipe_out_valid & full & ~pop;

   always_comb begin
      inflight_nxt = inflight;
      if (issue && !pipe_out_valid)
         inflight_nxt = inflight + 1'b1;
      else if (!issue && pipe_out_valid && inflight != '0)
         inflight_nxt = inflight - 1'b1;
   end

   always_comb begin
      fifo_cnt_nxt = fifo_cnt;
      case ({push, pop})
         2'b10:   fifo_cnt_nxt = fifo_cnt + 1'b1;
         2'b01:   fifo_cnt_nxt = fifo_cnt - 1'b1;
         default: fifo_cnt_nxt = fifo_cnt;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         inflight <= '0;
         fifo_cnt <= '0;
         wptr     <= '0;
         rptr     <= '0;
         ovf_q    <= 1'b0;
      end else begin
         inflight <= inflight_nxt;
         fifo_cnt <= fifo_cnt_nxt;
         if (push)
            wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
         if (pop)
            rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
         if (drop)
            ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         mem[wptr] <= pipe_out_data;
   end

`ifdef PIPE_CATCH_CHECK_EN
   logic [LAT-1:0] iss_sr;
   logic           err_q;

   // Shadow of the pipe: its oldest bit must match every return exactly.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         iss_sr <= '0;
         err_q  <= 1'b0;
      end else begin
         iss_sr <= (iss_sr << 1) | LAT'(issue);
         if ((iss_sr[LAT-1] != pipe_out_valid) || (pipe_out_valid && inflight == '0))
            err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_catch.sv
// Directed bench for pipe_catch: an 8-deep instance and a 5-deep instance, each fed by a behavioural LAT pipe.
module tb_pipe_catch;

   localparam int LAT = 4;
`ifdef PIPE_CATCH_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        clock, rst;
   logic        up_valid, up_ready, pipe_out_valid, down_valid, down_ready, ovf, err;
   logic [31:0] pipe_out_data, down_data;
   logic [3:0]  credit;
   logic        up_valid5, up_ready5, pipe_out_valid5, down_valid5, down_ready5, ovf5, err5;
   logic [31:0] pipe_out_data5, down_data5;
   logic [2:0]  credit5;

   int checks = 0;
   int errors = 0;
   logic        sv8 [8];
   logic [31:0] sd8 [8];
   logic        sv5 [8];
   logic [31:0] sd5 [8];
   int seq8, seq5, acc8, acc5, rx5, dly;

   pipe_catch #(.LAT(LAT), .DSIZE(32), .DEPTH(8)) dut (
      .clock(clock), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
      .pipe_out_valid(pipe_out_valid), .pipe_out_data(pipe_out_data),
      .down_valid(down_valid), .down_data(down_data), .down_ready(down_ready),
      .credit(credit), .ovf(ovf), .err(err));

   pipe_catch #(.LAT(LAT), .DSIZE(32), .DEPTH(5)) dut5 (
      .clock(clock), .rst(rst), .up_valid(up_valid5), .up_ready(up_ready5),
      .pipe_out_valid(pipe_out_valid5), .pipe_out_data(pipe_out_data5),
      .down_valid(down_valid5), .down_data(down_data5), .down_ready(down_ready5),
      .credit(credit5), .ovf(ovf5), .err(err5));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_model();
      for (int i = 0; i < 8; i++) begin
         sv8[i] = 1'b0; sd8[i] = '0; sv5[i] = 1'b0; sd5[i] = '0;
      end
      pipe_out_valid = 1'b0; pipe_out_data = '0;
      pipe_out_valid5 = 1'b0; pipe_out_data5 = '0;
   endtask

   // One clock: log this cycle's issues into the pipe models, advance, drive returns.
   task automatic tick();
      logic iss8, iss5;
      iss8 = up_valid & up_ready;
      iss5 = up_valid5 & up_ready5;
      for (int i = 7; i > 0; i--) begin
         sv8[i] = sv8[i-1]; sd8[i] = sd8[i-1];
         sv5[i] = sv5[i-1]; sd5[i] = sd5[i-1];
      end
      sv8[0] = iss8; sd8[0] = seq8;
      sv5[0] = iss5; sd5[0] = seq5;
      if (iss8) begin seq8++; acc8++; end
      if (iss5) begin seq5++; acc5++; end
      @(posedge clock);
      #1;
      pipe_out_valid  = sv8[LAT-1+dly];
      pipe_out_data   = sd8[LAT-1+dly];
      pipe_out_valid5 = sv5[LAT-1];
      pipe_out_data5  = sd5[LAT-1];
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      clr_model();
      up_valid = 1'b0; down_ready = 1'b0; up_valid5 = 1'b0; down_ready5 = 1'b0;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; dly = 0;
      up_valid = 1'b0; down_ready = 1'b0; up_valid5 = 1'b0; down_ready5 = 1'b0;
      seq8 = 0; seq5 = 0; acc8 = 0; acc5 = 0; rx5 = 0;
      clr_model();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_credit", 32'(credit), 8);
      chk("rst_up_ready", 32'(up_ready), 1);
      chk("rst_down_valid", 32'(down_valid), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_credit5", 32'(credit5), 5);
      rst = 1'b0;

      // Full-rate streaming: first result visible at cycle LAT+1.
      seq8 = 0; down_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         up_valid = (c < 12);
         chk("stream_up_ready", 32'(up_ready), 1);
         chk("stream_down_valid", 32'(down_valid), 32'(c >= 5 && c < 17));
         if (c >= 5 && c < 17)
            chk("stream_data", down_data, 32'(c - 5));
         if (c == 8)
            chk("stream_credit", 32'(credit), 3);
         tick();
      end

      // Backpressure: exactly DEPTH issues, then ordered drain.
      seq8 = 0; acc8 = 0; down_ready = 1'b0; up_valid = 1'b1;
      for (int c = 0; c < 15; c++) begin
         chk("bp_up_ready", 32'(up_ready), 32'(c < 8));
         if (c >= 5)
            chk("bp_head_stable", down_data, 0);
         tick();
      end
      chk("bp_accepted", 32'(acc8), 8);
      chk("bp_credit", 32'(credit), 0);
      chk("bp_full_valid", 32'(down_valid), 1);
      chk("bp_ovf", 32'(ovf), 0);
      up_valid = 1'b0; down_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("bp_drain_valid", 32'(down_valid), 1);
         chk("bp_drain_data", down_data, 32'(k));
         tick();
         if (k == 0) begin
            chk("bp_ready_back", 32'(up_ready), 1);
            chk("bp_credit_back", 32'(credit), 1);
         end
      end
      chk("bp_empty", 32'(down_valid), 0);
      chk("bp_credit_end", 32'(credit), 8);

      // Spurious return while full: dropped, ovf sticky, contents intact.
      seq8 = 0; down_ready = 1'b0; up_valid = 1'b1;
      repeat (15) tick();
      up_valid = 1'b0;
      pipe_out_valid = 1'b1; pipe_out_data = 32'hdead_beef;
      tick();
      chk("ovf_set", 32'(ovf), 1);
      chk("ovf_err", 32'(err), 32'(EXP_ERR));
      chk("ovf_credit", 32'(credit), 0);
      down_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("ovf_drain_data", down_data, 32'(k));
         tick();
      end
      chk("ovf_empty", 32'(down_valid), 0);
      chk("ovf_no_underflow", 32'(credit), 8);

      // Asynchronous reset in the middle of traffic.
      seq8 = 0; up_valid = 1'b1; down_ready = 1'b0;
      repeat (6) tick();
      chk("mid_pre_valid", 32'(down_valid), 1);
      rst = 1'b1;
      #1;
      chk("mid_credit", 32'(credit), 8);
      chk("mid_up_ready", 32'(up_ready), 1);
      chk("mid_down_valid", 32'(down_valid), 0);
      chk("mid_ovf", 32'(ovf), 0);
      chk("mid_err", 32'(err), 0);
      pulse_rst();

      // Return one cycle late.
      dly = 1; seq8 = 0; up_valid = 1'b1; down_ready = 1'b1;
      tick();
      up_valid = 1'b0;
      for (int c = 1; c < 9; c++) begin
         chk("late_down_valid", 32'(down_valid), 32'(c == 6));
         tick();
      end
      chk("late_err", 32'(err), 32'(EXP_ERR));
      pulse_rst();
      dly = 0;

      // DEPTH=5 instance: 20 items across pointer wraps with random stalls.
      seq5 = 0; acc5 = 0; rx5 = 0;
      for (int c = 0; c < 300; c++) begin
         up_valid5 = (acc5 < 20);
         down_ready5 = 1'($urandom_range(0, 1));
         if (down_valid5 && down_ready5) begin
            chk("d5_data", down_data5, 32'(rx5));
            rx5++;
         end
         tick();
      end
      chk("d5_count", 32'(rx5), 20);
      chk("d5_ovf", 32'(ovf5), 0);
      chk("d5_credit", 32'(credit5), 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
